// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if
//   Bundles the command stream, the response stream and the Wishbone (B4,
//   pipelined) initiator signals of wb_cmd_master.
//   Ports / signals:
//     cmd_valid, cmd_ready, cmd_we, cmd_addr[31:0], cmd_wdata[31:0]  command stream
//     rsp_valid, rsp_ready, rsp_rdata[31:0], rsp_err                 response stream
//     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr[31:0], o_wb_data[31:0]  bus request
//     i_wb_ack, i_wb_stall, i_wb_data[31:0]                          bus response
//   Modports: master (the initiator), slave (sequencer + responder side).
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic [31:0] i_wb_data;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  i_wb_ack, i_wb_stall, i_wb_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output i_wb_ack, i_wb_stall, i_wb_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Single-outstanding Wishbone B4 pipelined initiator. Each accepted command
//   (one 32-bit read or write) becomes one bus cycle; the result comes back on
//   the response stream. All outputs are registered.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    wb_cmd_master_if.master (command, response and Wishbone signals)
//   Parameters:
//     TIMEOUT_CYCLES  cycles spent in REQ+WAIT before the transfer is aborted
//     TIMEOUT_W       timeout counter width (TIMEOUT_CYCLES < 2**TIMEOUT_W)
//   Optional feature: define WB_MASTER_TIMEOUT_EN to enable the transfer
//   timeout. Without it REQ/WAIT wait indefinitely and rsp_err stays 0.
module wb_cmd_master #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd255,
  parameter int          TIMEOUT_W      = 8
) (
  input logic            clk,
  input logic            reset,
  wb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_reg, state_next;
  logic        cmd_ready_reg, cmd_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        cyc_reg, cyc_next;
  logic        stb_reg, stb_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;

  logic        cmd_accept;
  logic        ack_valid;
  logic        timeout_hit;

  assign cmd_accept = (state_reg == ST_IDLE) && bus.cmd_valid && cmd_ready_reg;

  // An ack only counts once the request has been taken: in WAIT, or in REQ
  // in the same cycle the responder drops stall. Acks in IDLE/RESP are stray.
  assign ack_valid = bus.i_wb_ack &&
                     ((state_reg == ST_WAIT) ||
                      ((state_reg == ST_REQ) && !bus.i_wb_stall));

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [TIMEOUT_W-1:0] count_reg, count_next;
  logic                 in_xfer;

  assign in_xfer     = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  // An ack in the expiry cycle wins over the timeout.
  assign timeout_hit = in_xfer && !ack_valid && (count_reg == TIMEOUT_LAST);

  always_comb begin
    count_next = count_reg;
    if (cmd_accept) begin
      count_next = '0;
    end else if (in_xfer && !ack_valid) begin
      count_next = count_reg + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // Parameters only matter when the timeout is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 32'd0) ^ (TIMEOUT_W == 0);
`endif

  always_comb begin
    state_next     = state_reg;
    cmd_ready_next = cmd_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (cmd_accept) begin
          we_next        = bus.cmd_we;
          addr_next      = bus.cmd_addr;
          data_next      = bus.cmd_wdata;
          cyc_next       = 1'b1;
          stb_next       = 1'b1;
          cmd_ready_next = 1'b0;
          state_next     = ST_REQ;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (ack_valid) begin
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          rsp_rdata_next = we_reg ? 32'd0 : bus.i_wb_data;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if (timeout_hit) begin
          cyc_next       = 1'b0;
          stb_next       = 1'b0;
          rsp_rdata_next = 32'd0;
          rsp_err_next   = 1'b1;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else if ((state_reg == ST_REQ) && !bus.i_wb_stall) begin
          stb_next   = 1'b0;
          state_next = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      data_reg      <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.o_wb_cyc  = cyc_reg;
  assign bus.o_wb_stb  = stb_reg;
  assign bus.o_wb_we   = we_reg;
  assign bus.o_wb_addr = addr_reg;
  assign bus.o_wb_data = data_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master
//   Self-checking bench for wb_cmd_master: directed scenarios with literal
//   expectations followed by randomized traffic against a transaction-level
//   model. One line is printed per completed response.
`timescale 1ns/1ps
module tb_wb_cmd_master;
  localparam int TB_TO = 16;

  logic clk = 1'b0;
  logic reset;

  wb_cmd_master_if bus();

  wb_cmd_master #(
    .TIMEOUT_CYCLES(32'd16),
    .TIMEOUT_W     (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0b expected=%0b", name, cycle_no, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cycle_no, act, exp);
    end
  endtask

  // ---------------- responder ----------------
  // mode 0: random stall/ack, stray acks while idle
  // mode 1: stall for stall_left cycles, ack the cycle after acceptance
  // mode 2: never acks a live request, stray acks while cyc is low
  int          resp_mode  = 1;
  int          stall_left = 0;
  logic [31:0] resp_data  = 32'd0;

  always @(posedge clk) begin
    #1;
    bus.i_wb_data  = $urandom;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_stall = 1'b0;
    case (resp_mode)
      0: begin
        if (bus.o_wb_cyc && bus.o_wb_stb) begin
          bus.i_wb_stall = ($urandom_range(0, 2) == 0);
          bus.i_wb_ack   = !bus.i_wb_stall && ($urandom_range(0, 1) == 0);
        end else if (bus.o_wb_cyc) begin
          bus.i_wb_ack   = ($urandom_range(0, 2) == 0);
          bus.i_wb_stall = ($urandom_range(0, 1) == 0);
        end else begin
          bus.i_wb_ack   = ($urandom_range(0, 7) == 0);
          bus.i_wb_stall = ($urandom_range(0, 1) == 0);
        end
      end
      1: begin
        if (bus.o_wb_cyc && bus.o_wb_stb) begin
          if (stall_left > 0) begin
            bus.i_wb_stall = 1'b1;
            stall_left--;
          end
        end else if (bus.o_wb_cyc) begin
          bus.i_wb_ack  = 1'b1;
          bus.i_wb_data = resp_data;
        end
      end
      default: begin
        if (!bus.o_wb_cyc) bus.i_wb_ack = ($urandom_range(0, 1) == 0);
      end
    endcase
  end

  // ---------------- transaction-level model + compare ----------------
  // m_busy: a command was taken and its bus cycle is still open
  // m_taken: the responder has accepted the request (stall low while stb)
  // m_pend: a response is waiting to be consumed
  bit          m_valid = 0;
  bit          m_busy  = 0;
  bit          m_taken = 0;
  bit          m_pend  = 0;
  bit          m_we    = 0;
  bit          m_err   = 0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  int          m_wait  = 0;
  int          n_rsp   = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check1("cmd_ready", bus.cmd_ready, !m_busy && !m_pend);
      check1("wb_cyc", bus.o_wb_cyc, m_busy);
      check1("wb_stb", bus.o_wb_stb, m_busy && !m_taken);
      check1("rsp_valid", bus.rsp_valid, m_pend);
      if (m_busy) begin
        check1("wb_we", bus.o_wb_we, m_we);
        check32("wb_addr", bus.o_wb_addr, m_addr);
        check32("wb_data", bus.o_wb_data, m_wdata);
      end
      if (m_pend) begin
        check32("rsp_rdata", bus.rsp_rdata, m_rdata);
        check1("rsp_err", bus.rsp_err, m_err);
        if (bus.rsp_ready && !reset) begin
          n_rsp++;
          $display("rsp %0d: we=%0d addr=0x%08h rdata=0x%08h err=%0d cycle=%0d",
                   n_rsp, m_we, m_addr, bus.rsp_rdata, bus.rsp_err, cycle_no);
        end
      end
    end

    // advance the model by the inputs seen this cycle
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_taken = 0;
      m_pend  = 0;
    end else if (m_valid) begin
      if (m_busy) begin
        if (bus.i_wb_ack && (m_taken || !bus.i_wb_stall)) begin
          m_busy  = 0;
          m_pend  = 1;
          m_err   = 0;
          m_rdata = m_we ? 32'd0 : bus.i_wb_data;
        end else begin
`ifdef WB_MASTER_TIMEOUT_EN
          if (m_wait == TB_TO - 1) begin
            m_busy  = 0;
            m_pend  = 1;
            m_err   = 1;
            m_rdata = 32'd0;
          end
`endif
          if (!m_taken && !bus.i_wb_stall) m_taken = 1;
          m_wait++;
        end
      end else if (m_pend) begin
        if (bus.rsp_ready) m_pend = 0;
      end else if (bus.cmd_valid) begin
        m_busy  = 1;
        m_taken = 0;
        m_wait  = 0;
        m_we    = bus.cmd_we;
        m_addr  = bus.cmd_addr;
        m_wdata = bus.cmd_wdata;
      end
    end
  end

  // ---------------- simple activity counters ----------------
  int stb_cnt    = 0;
  int stb_we_cnt = 0;
  int cyc_we_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_wb_stb) stb_cnt++;
    if (bus.o_wb_stb && bus.o_wb_we) stb_we_cnt++;
    if (bus.o_wb_cyc && bus.o_wb_we) cyc_we_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      output int acc_cycle);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    acc_cycle = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc_cycle = cycle_no;
        break;
      end
    end
    check1("cmd_accept", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rsp_cycle);
    rsp_cycle = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rsp_cycle = cycle_no;
        break;
      end
    end
    check1("rsp_seen", bus.rsp_valid, 1'b1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cycle_no);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a, r, rc, n0;
    bit acc;

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    tick(3);
    reset = 1'b0;

    // reset values
    @(negedge clk);
    check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check1("rst_cyc", bus.o_wb_cyc, 1'b0);
    check1("rst_stb", bus.o_wb_stb, 1'b0);
    check1("rst_we", bus.o_wb_we, 1'b0);
    check32("rst_addr", bus.o_wb_addr, 32'd0);
    check32("rst_data", bus.o_wb_data, 32'd0);
    check1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check1("rst_rsp_err", bus.rsp_err, 1'b0);
    check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);

    // 1: simple write, no stall, ack one cycle after acceptance
    resp_mode     = 1;
    stall_left    = 0;
    bus.rsp_ready = 1'b1;
    stb_cnt = 0; stb_we_cnt = 0;
    send(1'b1, 32'h3000_0000, 32'h0000_00A5, a);
    wait_rsp(r);
    check32("t1_latency", r - a, 32'd3);
    check32("t1_rdata", bus.rsp_rdata, 32'd0);
    check1("t1_err", bus.rsp_err, 1'b0);
    tick(2);
    check32("t1_stb_cycles", stb_cnt, 32'd1);
    check32("t1_stb_we_cycles", stb_we_cnt, 32'd1);

    // 2: read returning 0x5, we low throughout
    resp_data  = 32'h0000_0005;
    cyc_we_cnt = 0;
    send(1'b0, 32'h3000_0004, 32'hDEAD_BEEF, a);
    wait_rsp(r);
    check32("t2_rdata", bus.rsp_rdata, 32'h0000_0005);
    check1("t2_err", bus.rsp_err, 1'b0);
    tick(2);
    check32("t2_we_cycles", cyc_we_cnt, 32'd0);

    // 3: write stalled for 3 cycles
    stall_left = 3;
    stb_cnt    = 0;
    send(1'b1, 32'h3000_0008, 32'h1234_5678, a);
    wait_rsp(r);
    check32("t3_latency", r - a, 32'd6);
    tick(2);
    check32("t3_stb_cycles", stb_cnt, 32'd4);

`ifdef WB_MASTER_TIMEOUT_EN
    // 4: unmapped read, no ack -> timeout
    resp_mode = 2;
    send(1'b0, 32'h4000_0000, 32'd0, a);
    wait_rsp(r);
    check32("t4_cyc_fall", r - (a + 1), 32'd16);
    check1("t4_err", bus.rsp_err, 1'b1);
    check32("t4_rdata", bus.rsp_rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check1("t4_no_cyc", bus.o_wb_cyc, 1'b0);
    end
    resp_mode = 1;
`endif

    // 5: response back-pressure with a second command waiting
    resp_data     = 32'hCAFE_0001;
    bus.rsp_ready = 1'b0;
    send(1'b0, 32'h3000_000C, 32'd0, a);
    wait_rsp(r);
    check32("t5_rdata", bus.rsp_rdata, 32'hCAFE_0001);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 32'h3000_0010;
    bus.cmd_wdata = 32'h0000_5A5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("t5_hold_valid", bus.rsp_valid, 1'b1);
      check1("t5_hold_ready", bus.cmd_ready, 1'b0);
      check1("t5_hold_cyc", bus.o_wb_cyc, 1'b0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rc = cycle_no;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check1("t5_accept", bus.cmd_ready, 1'b1);
    check32("t5_accept_cycle", cycle_no - rc, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check1("t5_second_stb", bus.o_wb_stb, 1'b1);
    check32("t5_second_addr", bus.o_wb_addr, 32'h3000_0010);
    bus.rsp_ready = 1'b1;
    wait_rsp(r);
    tick(1);

    // 6: reset pulse while waiting for ack
    resp_mode = 2;
    send(1'b0, 32'h3000_0014, 32'd0, a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_wb_cyc && !bus.o_wb_stb) break;
    end
    check1("t6_in_wait", bus.o_wb_cyc && !bus.o_wb_stb, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check1("t6_cyc", bus.o_wb_cyc, 1'b0);
    check1("t6_stb", bus.o_wb_stb, 1'b0);
    check1("t6_rsp_valid", bus.rsp_valid, 1'b0);
    check1("t6_cmd_ready", bus.cmd_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("t6_no_rsp", bus.rsp_valid, 1'b0);
    end

    // randomized traffic
    resp_mode = 0;
    n0 = n_rsp;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      reset = ($urandom_range(0, 149) == 0);
      if (!bus.cmd_valid || acc) begin
        bus.cmd_valid = ($urandom_range(0, 2) != 0);
        bus.cmd_we    = ($urandom_range(0, 1) == 0);
        bus.cmd_addr  = $urandom & 32'hFFFF_FFFC;
        bus.cmd_wdata = $urandom;
      end
      bus.rsp_ready = ($urandom_range(0, 1) == 0);
    end
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.o_wb_cyc && !bus.rsp_valid) break;
    end
    check1("drain_idle", !bus.o_wb_cyc && !bus.rsp_valid, 1'b1);
    check1("rand_progress", (n_rsp - n0) >= 10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
